rds_msg_builder: RTL and testbench
==================================

RDS_MSG_BUILDER -- requirements
Module: rds_msg_builder

Interface
REQ-001 Parameter C_BASE_ADDR, default 0: first byte address written in the RDS message RAM.
REQ-002 clk  input  1  system clock (25 MHz domain); every register updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  single-cycle request to rebuild the message; sampled only in IDLE.
REQ-005 pi  input  16  program identification code.
REQ-006 pty  input  5  program type.
REQ-007 tp, ta, ms, di  input  1 each  traffic-program, traffic-announcement, music/speech and decoder-info flags.
REQ-008 af  input  16  block C content, identical in every group.
REQ-009 ps  input  64  8-character program-service name; char 0 = ps[63:56].
REQ-010 wr_addr  output  9  byte address into the RDS message RAM.
REQ-011 wr_data  output  8  byte written.
REQ-012 wr_en  output  1  write strobe, one byte per cycle while high.
REQ-013 busy  output  1  high while a build is in progress.
REQ-014 done  output  1  one-cycle completion pulse.

Function
REQ-015 The block SHALL produce four RDS group-0A records (g = 0..3), each 4 blocks x 26 bits = 104 bits = 13 bytes, 52 bytes in total.
REQ-016 Each group SHALL use this data: A = pi; B = {4'b0000, 1'b0, tp, pty, ta, ms, DIbit, g[1:0]}, where DIbit = di; C = af; D = {ps char 2g, ps char 2g+1}.
REQ-017 Each block SHALL be the 16 data bits MSB-first, followed by a 10-bit checkword, MSB-first.
  - Checkword = (CRC of the data with generator x^10+x^8+x^7+x^5+x^4+x^3+1) XOR offset.
  - Offsets: A = 0x0FC, B = 0x198, C = 0x168, D = 0x1B4.
REQ-018 Byte packing: the 104-bit group stream SHALL be split MSB-first, so byte k holds stream bits 8k..8k+7, first-transmitted bit at wr_data[7].
REQ-019 Addressing: byte k of group g SHALL be written to (C_BASE_ADDR + 13g + k) mod 512.
REQ-020 The FSM SHALL have the states IDLE, LATCH, BLK, CRC, WRITE and FIN.
REQ-021 IDLE -> LATCH on start=1.
  - LATCH registers pi, pty, flags, af and ps.
  - Inputs SHALL NOT be re-sampled until the next build.
REQ-022 Per block: BLK (1 cycle, load data and clear CRC) -> CRC (16 cycles, one data bit per cycle).
  - 17 cycles per block, 68 cycles per group.
REQ-023 WRITE SHALL emit 13 consecutive wr_en cycles per group.
  - It then goes to BLK for the next group, or to FIN after g = 3.
REQ-024 Timing, with start sampled at cycle 0 (LATCH occupies cycle 0):
  - busy=1 from cycle 1.
  - Group g: CRC phase at cycles 81g+1..81g+68; writes at cycles 81g+69..81g+81.
  - Last write at cycle 324.
  - Cycle 325 (FIN): done=1, busy=0, wr_en=0.
  - Return to IDLE at cycle 326.
REQ-025 start asserted while busy SHALL be ignored; it is neither queued nor allowed to restart the build.
REQ-026 start asserted in the same cycle as done SHALL be ignored; a new build requires start while in IDLE.
REQ-027 Input changes during a build SHALL NOT affect the bytes written.
REQ-028 Outside WRITE, wr_en SHALL be 0; wr_addr and wr_data are don't-care.
REQ-029 Address arithmetic SHALL be 9-bit and wrap modulo 512 (e.g. C_BASE_ADDR = 500 writes group 0 byte 12 to address 0).

Reset
REQ-030 reset=1 SHALL force the following at the next edge, regardless of state:
  - state = IDLE;
  - busy = 0, done = 0, wr_en = 0, wr_addr = 0, wr_data = 0;
  - CRC and bit/byte/group counters cleared.
REQ-031 Reset during a build SHALL abort it with no done pulse and no further writes; RAM contents already written are left as-is.
REQ-032 start coinciding with reset SHALL be ignored.

Verification
REQ-033 Zero data: pi = 0 and everything else 0, start -> group 0 bytes 0..2 = 0x00, 0x00, 0x3F; bits 0x0FC appear as the block A checkword; done at cycle 325.
REQ-034 PS name "RADIO  1", PI = 0x9201 -> all 52 bytes match a bit-serial reference model.
  - D of group 0 = 0x5241 ("RA"); group 3 block B low bits = 2'b11.
REQ-035 C_BASE_ADDR = 500 -> write addresses 500..511, then 0..39, 52 writes total, no gaps within a group, no duplicates.
REQ-036 start re-pulsed at cycles 10 and 200, and start held high through cycle 325 -> exactly one build, exactly one done pulse.
REQ-037 reset at cycle 150 (mid-build) -> wr_en low from cycle 151, busy = 0, no done; a fresh start then completes normally in 325 cycles.

Source files
------------

// File: rtl/rds_msg_builder.sv
// RDS group-0A message builder: assembles four 104-bit groups (PI, flags/PTY,
// AF, PS pair), computes the RDS checkwords bit-serially and writes the
// result as 52 bytes into the RDS message RAM.
module rds_msg_builder #(
    parameter int unsigned C_BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] pi,
    input  logic [4:0]  pty,
    input  logic        tp,
    input  logic        ta,
    input  logic        ms,
    input  logic        di,
    input  logic [15:0] af,
    input  logic [63:0] ps,
    output logic [8:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_en,
    output logic        busy,
    output logic        done
);

    localparam int unsigned DATA_W    = 16;
    localparam int unsigned CRC_W     = 10;
    localparam int unsigned ADDR_W    = 9;
    localparam int unsigned BYTE_W    = 8;
    localparam int unsigned GRP_BITS  = 104;
    localparam int unsigned BLK_BITS  = DATA_W + CRC_W;
    localparam int unsigned LAST_BYTE = 12;

    // Generator x^10+x^8+x^7+x^5+x^4+x^3+1 without the implicit x^10 term
    localparam logic [CRC_W-1:0] CRC_POLY = 10'h1B9;
    localparam logic [CRC_W-1:0] OFS_A    = 10'h0FC;
    localparam logic [CRC_W-1:0] OFS_B    = 10'h198;
    localparam logic [CRC_W-1:0] OFS_C    = 10'h168;
    localparam logic [CRC_W-1:0] OFS_D    = 10'h1B4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        BLK   = 3'd2,
        CRC   = 3'd3,
        WRITE = 3'd4,
        FIN   = 3'd5
    } state_t;

    state_t state_q, state_d;

    // Snapshot of the message inputs taken once per build
    logic [15:0] pi_q;
    logic [4:0]  pty_q;
    logic        tp_q, ta_q, ms_q, di_q;
    logic [15:0] af_q;
    logic [63:0] ps_q;

    // Build datapath
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [1:0]          blk_cnt_q, blk_cnt_d;
    logic [1:0]          grp_cnt_q, grp_cnt_d;
    logic [3:0]          byte_cnt_q, byte_cnt_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [GRP_BITS-1:0] grp_sr_q, grp_sr_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;

    // Registered output next values
    logic [ADDR_W-1:0] wr_addr_d;
    logic [BYTE_W-1:0] wr_data_d;
    logic              wr_en_d;
    logic              busy_d;
    logic              done_d;

    // Block helpers
    logic [DATA_W-1:0] blk_word;
    logic [CRC_W-1:0]  blk_ofs;
    logic              crc_fb;
    logic [CRC_W-1:0]  crc_step;

    // Select the 16-bit data word and offset word of the current block
    always_comb begin
        blk_word = pi_q;
        blk_ofs  = OFS_A;
        case (blk_cnt_q)
            2'd0: begin
                blk_word = pi_q;
                blk_ofs  = OFS_A;
            end
            2'd1: begin
                blk_word = {4'b0000, 1'b0, tp_q, pty_q, ta_q, ms_q, di_q, grp_cnt_q};
                blk_ofs  = OFS_B;
            end
            2'd2: begin
                blk_word = af_q;
                blk_ofs  = OFS_C;
            end
            default: begin
                case (grp_cnt_q)
                    2'd0:    blk_word = ps_q[63:48];
                    2'd1:    blk_word = ps_q[47:32];
                    2'd2:    blk_word = ps_q[31:16];
                    default: blk_word = ps_q[15:0];
                endcase
                blk_ofs = OFS_D;
            end
        endcase
    end

    // One step of the serial checkword divider, MSB-first
    always_comb begin
        crc_fb   = blk_word[4'd15 - bit_cnt_q] ^ crc_q[CRC_W-1];
        crc_step = {crc_q[CRC_W-2:0], 1'b0} ^ (crc_fb ? CRC_POLY : '0);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, datapath and output next values
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        blk_cnt_d  = blk_cnt_q;
        grp_cnt_d  = grp_cnt_q;
        byte_cnt_d = byte_cnt_q;
        crc_d      = crc_q;
        grp_sr_d   = grp_sr_q;
        ptr_d      = ptr_q;
        wr_addr_d  = wr_addr;
        wr_data_d  = wr_data;
        wr_en_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LATCH;
                end
            end
            LATCH: begin
                bit_cnt_d  = '0;
                blk_cnt_d  = '0;
                grp_cnt_d  = '0;
                byte_cnt_d = '0;
                crc_d      = '0;
                ptr_d      = ADDR_W'(C_BASE_ADDR);
                state_d    = BLK;
            end
            BLK: begin
                bit_cnt_d = '0;
                crc_d     = '0;
                state_d   = CRC;
            end
            CRC: begin
                crc_d = crc_step;
                if (bit_cnt_q == 4'd15) begin
                    // Append data word and checkword to the group stream
                    grp_sr_d  = {grp_sr_q[GRP_BITS-BLK_BITS-1:0], blk_word, crc_step ^ blk_ofs};
                    bit_cnt_d = '0;
                    if (blk_cnt_q == 2'd3) begin
                        blk_cnt_d  = '0;
                        byte_cnt_d = '0;
                        state_d    = WRITE;
                    end else begin
                        blk_cnt_d = blk_cnt_q + 2'd1;
                        state_d   = BLK;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            WRITE: begin
                if (byte_cnt_q == 4'(LAST_BYTE)) begin
                    byte_cnt_d = '0;
                    if (grp_cnt_q == 2'd3) begin
                        state_d = FIN;
                    end else begin
                        grp_cnt_d = grp_cnt_q + 2'd1;
                        state_d   = BLK;
                    end
                end else begin
                    byte_cnt_d = byte_cnt_q + 4'd1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every cycle spent in WRITE emits the leading byte of the stream
        if (state_d == WRITE) begin
            wr_en_d   = 1'b1;
            wr_data_d = grp_sr_d[GRP_BITS-1 -: BYTE_W];
            wr_addr_d = ptr_q;
            ptr_d     = ptr_q + 9'd1;
            grp_sr_d  = {grp_sr_d[GRP_BITS-BYTE_W-1:0], 8'h00};
        end

        busy_d = (state_d == BLK) || (state_d == CRC) || (state_d == WRITE);
        done_d = (state_d == FIN);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_q  <= '0;
            blk_cnt_q  <= '0;
            grp_cnt_q  <= '0;
            byte_cnt_q <= '0;
            crc_q      <= '0;
            grp_sr_q   <= '0;
            ptr_q      <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_en      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            blk_cnt_q  <= blk_cnt_d;
            grp_cnt_q  <= grp_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            crc_q      <= crc_d;
            grp_sr_q   <= grp_sr_d;
            ptr_q      <= ptr_d;
            wr_addr    <= wr_addr_d;
            wr_data    <= wr_data_d;
            wr_en      <= wr_en_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

    // Input snapshot, taken only in LATCH so later input changes are ignored
    always_ff @(posedge clk) begin
        if (reset) begin
            pi_q  <= '0;
            pty_q <= '0;
            tp_q  <= 1'b0;
            ta_q  <= 1'b0;
            ms_q  <= 1'b0;
            di_q  <= 1'b0;
            af_q  <= '0;
            ps_q  <= '0;
        end else if (state_q == LATCH) begin
            pi_q  <= pi;
            pty_q <= pty;
            tp_q  <= tp;
            ta_q  <= ta;
            ms_q  <= ms;
            di_q  <= di;
            af_q  <= af;
            ps_q  <= ps;
        end
    end

endmodule

// File: tb/tb_rds_msg_builder.sv
// Testbench for rds_msg_builder: two instances (base 0 and base 500) share the
// stimulus; every cycle of each build is compared with a group-level model.
module tb_rds_msg_builder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] pi;
    logic [4:0]  pty;
    logic        tp, ta, ms, di;
    logic [15:0] af;
    logic [63:0] ps;

    logic [8:0] wa [2];
    logic [7:0] wd [2];
    logic       wen [2];
    logic       bsy [2];
    logic       dn [2];

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] exp_b [52];
    logic [7:0] got [2][52];

    rds_msg_builder #(.C_BASE_ADDR(0)) u_dut0 (
        .clk(clk), .reset(reset), .start(start), .pi(pi), .pty(pty),
        .tp(tp), .ta(ta), .ms(ms), .di(di), .af(af), .ps(ps),
        .wr_addr(wa[0]), .wr_data(wd[0]), .wr_en(wen[0]), .busy(bsy[0]), .done(dn[0])
    );

    rds_msg_builder #(.C_BASE_ADDR(500)) u_dut1 (
        .clk(clk), .reset(reset), .start(start), .pi(pi), .pty(pty),
        .tp(tp), .ta(ta), .ms(ms), .di(di), .af(af), .ps(ps),
        .wr_addr(wa[1]), .wr_data(wd[1]), .wr_en(wen[1]), .busy(bsy[1]), .done(dn[1])
    );

    // 25 MHz clock
    always #20 clk = ~clk;

    // Single comparison point: counts and reports
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Checkword by polynomial long division of d*x^10, then offset
    function automatic logic [9:0] checkword(input logic [15:0] d, input logic [9:0] ofs);
        logic [25:0] v;
        v = {d, 10'd0};
        for (int i = 25; i >= 10; i--) begin
            if (v[i]) v = v ^ (26'(11'h5B9) << (i - 10));
        end
        return v[9:0] ^ ofs;
    endfunction

    // Expected 52 bytes from the current input values
    task automatic build_model();
        logic [15:0]  a, b, c, d;
        logic [103:0] s;
        for (int g = 0; g < 4; g++) begin
            a = pi;
            b = {4'b0000, 1'b0, tp, pty, ta, ms, di, 2'(g)};
            c = af;
            d = 16'(ps >> (48 - 16 * g));
            s = {a, checkword(a, 10'h0FC), b, checkword(b, 10'h198),
                 c, checkword(c, 10'h168), d, checkword(d, 10'h1B4)};
            for (int k = 0; k < 13; k++) exp_b[13 * g + k] = s[103 - 8 * k -: 8];
        end
    endtask

    task automatic rand_inputs();
        pi  = 16'($urandom);
        pty = 5'($urandom);
        tp  = 1'($urandom);
        ta  = 1'($urandom);
        ms  = 1'($urandom);
        di  = 1'($urandom);
        af  = 16'($urandom);
        ps  = {$urandom, $urandom};
    endtask

    // mode 0: single start; 1: extra start pulses at cycles 10 and 200;
    // 2: start held through cycle 325. rst_at >= 0 pulses reset in that cycle.
    task automatic run_build(input string name, input bit scramble, input int mode, input int rst_at);
        int  nwr [2];
        int  exp_nwr;
        int  g, k, off;
        bit  exp_we, exp_busy, exp_done, aborted;
        int  base;
        nwr[0] = 0;
        nwr[1] = 0;
        exp_nwr = 0;
        @(posedge clk); #1;
        build_model();
        start = 1'b1;
        @(posedge clk); #1;
        start = (mode == 2);
        for (int cyc = 0; cyc <= 335; cyc++) begin
            if (scramble && cyc >= 1) rand_inputs();
            if (mode == 1) start = (cyc == 10) || (cyc == 200);
            if (mode == 2) start = (cyc <= 325);
            reset = (cyc == rst_at);
            @(negedge clk);
            aborted  = (rst_at >= 0) && (cyc > rst_at);
            g        = (cyc - 1) / 81;
            off      = (cyc - 1) % 81;
            k        = off - 68;
            exp_we   = !aborted && cyc >= 1 && g <= 3 && off >= 68;
            exp_busy = !aborted && cyc >= 1 && cyc <= 324;
            exp_done = !aborted && cyc == 325;
            if (exp_we) exp_nwr++;
            for (int di_ = 0; di_ < 2; di_++) begin
                base = (di_ == 0) ? 0 : 500;
                if (wen[di_]) nwr[di_]++;
                check_eq($sformatf("%s.u%0d.c%0d.wr_en", name, di_, cyc), 32'(wen[di_]), 32'(exp_we));
                check_eq($sformatf("%s.u%0d.c%0d.busy", name, di_, cyc), 32'(bsy[di_]), 32'(exp_busy));
                check_eq($sformatf("%s.u%0d.c%0d.done", name, di_, cyc), 32'(dn[di_]), 32'(exp_done));
                if (exp_we) begin
                    got[di_][13 * g + k] = wd[di_];
                    check_eq($sformatf("%s.u%0d.c%0d.wr_addr", name, di_, cyc), 32'(wa[di_]),
                             32'((base + 13 * g + k) % 512));
                    check_eq($sformatf("%s.u%0d.c%0d.wr_data", name, di_, cyc), 32'(wd[di_]),
                             32'(exp_b[13 * g + k]));
                end
                if (rst_at >= 0 && cyc == rst_at + 1) begin
                    check_eq($sformatf("%s.u%0d.rst_addr", name, di_), 32'(wa[di_]), 32'd0);
                    check_eq($sformatf("%s.u%0d.rst_data", name, di_), 32'(wd[di_]), 32'd0);
                end
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        reset = 1'b0;
        for (int di_ = 0; di_ < 2; di_++)
            check_eq($sformatf("%s.u%0d.nwrites", name, di_), 32'(nwr[di_]), 32'(exp_nwr));
    endtask

    initial begin
        logic [103:0] s;
        reset = 1'b1;
        start = 1'b0;
        pi = '0; pty = '0; tp = 0; ta = 0; ms = 0; di = 0; af = '0; ps = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check_eq($sformatf("reset.u%0d.busy", d), 32'(bsy[d]), 32'd0);
            check_eq($sformatf("reset.u%0d.done", d), 32'(dn[d]), 32'd0);
            check_eq($sformatf("reset.u%0d.wr_en", d), 32'(wen[d]), 32'd0);
            check_eq($sformatf("reset.u%0d.wr_addr", d), 32'(wa[d]), 32'd0);
            check_eq($sformatf("reset.u%0d.wr_data", d), 32'(wd[d]), 32'd0);
        end
        @(posedge clk); #1;
        reset = 1'b0;

        // All-zero message: block A is zero data plus offset A
        run_build("zero", 1'b0, 0, -1);
        check_eq("zero.b0", 32'(got[0][0]), 32'h00);
        check_eq("zero.b1", 32'(got[0][1]), 32'h00);
        check_eq("zero.b2", 32'(got[0][2]), 32'h3F);

        // Named PS with inputs scrambled after the snapshot
        pi = 16'h9201; ps = "RADIO  1"; pty = 5'd10; tp = 1; ta = 0; ms = 1; di = 1; af = 16'hE20D;
        run_build("radio", 1'b1, 0, -1);
        s = '0;
        for (int k = 0; k < 13; k++) s = {s[95:0], got[0][k]};
        check_eq("radio.g0_d", 32'(s[25:10]), 32'h5241);
        s = '0;
        for (int k = 0; k < 13; k++) s = {s[95:0], got[0][39 + k]};
        check_eq("radio.g3_b_lsb", 32'(s[63:62]), 32'd3);

        // Start pulses while busy, then start held across done
        rand_inputs();
        run_build("repulse", 1'b1, 1, -1);
        rand_inputs();
        run_build("hold", 1'b0, 2, -1);

        // Abort mid-build, then a clean rebuild
        rand_inputs();
        run_build("abort", 1'b1, 0, 150);
        rand_inputs();
        run_build("after_abort", 1'b0, 0, -1);

        // Start coinciding with reset is ignored
        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check_eq($sformatf("rst_start.u%0d.busy", d), 32'(bsy[d]), 32'd0);
                check_eq($sformatf("rst_start.u%0d.wr_en", d), 32'(wen[d]), 32'd0);
            end
        end

        // A few more random builds
        for (int n = 0; n < 3; n++) begin
            rand_inputs();
            run_build($sformatf("rand%0d", n), 1'b1, 0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
